// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and dispatch-side handshake bundle for the
// decode queue. The slave modport is the queue's view; master is the
// environment's (IF on the input side, dispatch on the output side).
interface decode_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int OPW   = 6
);
  // fetch side
  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_ins;
  logic [XLEN-1:0]          in_pc;
  // dispatch side
  logic                     out_valid;
  logic                     out_ready;
  logic [OPW-1:0]           opcode;
  logic [6:0]               ophead;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [4:0]               rd;
  logic [XLEN-1:0]          imm;
  logic [XLEN-1:0]          pc;
  logic                     illegal;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_valid, in_ins, in_pc, out_ready,
    output in_ready, out_valid, opcode, ophead, rs1, rs2, rd, imm, pc,
           illegal, count
  );

  modport master (
    output in_valid, in_ins, in_pc, out_ready,
    input  in_ready, out_valid, opcode, ophead, rs1, rs2, rd, imm, pc,
           illegal, count
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: circular buffer of fetched RV32I instructions + PCs with a
// combinational decoder on the head entry and a valid/ready output.
// Optional macro DECODE_BYPASS_EN: an instruction arriving at an empty queue
// is presented on the output in the same cycle (and not stored if consumed).
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int OPW   = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           flush,
  decode_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // operation codes, 0 = invalid
  localparam logic [OPW-1:0] OP_LUI   = OPW'(1),  OP_AUIPC = OPW'(2);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(3),  OP_JALR  = OPW'(4);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(5),  OP_BNE   = OPW'(6);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(7),  OP_BGE   = OPW'(8);
  localparam logic [OPW-1:0] OP_BLTU  = OPW'(9),  OP_BGEU  = OPW'(10);
  localparam logic [OPW-1:0] OP_LB    = OPW'(11), OP_LH    = OPW'(12);
  localparam logic [OPW-1:0] OP_LW    = OPW'(13), OP_LBU   = OPW'(14);
  localparam logic [OPW-1:0] OP_LHU   = OPW'(15), OP_SB    = OPW'(16);
  localparam logic [OPW-1:0] OP_SH    = OPW'(17), OP_SW    = OPW'(18);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(19), OP_SLTI  = OPW'(20);
  localparam logic [OPW-1:0] OP_SLTIU = OPW'(21), OP_XORI  = OPW'(22);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(23), OP_ANDI  = OPW'(24);
  localparam logic [OPW-1:0] OP_SLLI  = OPW'(25), OP_SRLI  = OPW'(26);
  localparam logic [OPW-1:0] OP_SRAI  = OPW'(27), OP_ADD   = OPW'(28);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(29), OP_SLL   = OPW'(30);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(31), OP_SLTU  = OPW'(32);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(33), OP_SRL   = OPW'(34);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(35), OP_OR    = OPW'(36);
  localparam logic [OPW-1:0] OP_AND   = OPW'(37);

  // storage (not reset; validity is tracked by count)
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;

  logic empty, full, bypass, bypass_take, enq, deq, head_valid;
  logic [XLEN-1:0] sel_ins, sel_pc;

  assign empty      = (cnt == '0);
  assign full       = (cnt == CW'(DEPTH));
  assign head_valid = ~empty;
  assign bus.in_ready = rdy & ~full;

`ifdef DECODE_BYPASS_EN
  assign bypass = empty & bus.in_valid & rdy & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // a bypassed instruction consumed in its arrival cycle never gets stored
  assign bypass_take = bypass & bus.out_ready;
  assign enq = bus.in_valid & bus.in_ready & ~flush & ~bypass_take;
  assign deq = head_valid & bus.out_ready & rdy & ~flush;

  assign sel_ins = bypass ? bus.in_ins : ins_mem[head];
  assign sel_pc  = bypass ? bus.in_pc  : pc_mem[head];

  // pointer/occupancy update; flush wins over enqueue/dequeue, rdy gates all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (rdy) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (enq) tail <= tail + 1'b1;
        if (deq) head <= head + 1'b1;
        case ({enq, deq})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // entry write at tail
  always_ff @(posedge clk) begin
    if (enq) begin
      ins_mem[tail] <= bus.in_ins;
      pc_mem[tail]  <= bus.in_pc;
    end
  end

  logic [6:0]      maj;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [OPW-1:0]  dec_op;
  logic [XLEN-1:0] dec_imm;

  assign maj    = sel_ins[6:0];
  assign f3     = sel_ins[14:12];
  assign f7     = sel_ins[31:25];
  assign imm_i  = XLEN'($signed(sel_ins[31:20]));
  assign imm_s  = XLEN'($signed({sel_ins[31:25], sel_ins[11:7]}));
  assign imm_b  = XLEN'($signed({sel_ins[31], sel_ins[7], sel_ins[30:25],
                                 sel_ins[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({sel_ins[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({sel_ins[31], sel_ins[19:12], sel_ins[20],
                                 sel_ins[30:21], 1'b0}));
  assign imm_sh = XLEN'(sel_ins[24:20]);

  // opcode and immediate decode; unknown encodings leave op=0, imm=0
  always_comb begin
    dec_op  = '0;
    dec_imm = '0;
    case (maj)
      7'b0110111: begin dec_op = OP_LUI;   dec_imm = imm_u; end
      7'b0010111: begin dec_op = OP_AUIPC; dec_imm = imm_u; end
      7'b1101111: begin dec_op = OP_JAL;   dec_imm = imm_j; end
      7'b1100111: if (f3 == 3'b000) begin dec_op = OP_JALR; dec_imm = imm_i; end
      7'b1100011: begin
        case (f3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_op = '0;
        endcase
        if (dec_op != '0) dec_imm = imm_b;
      end
      7'b0000011: begin
        case (f3)
          3'b000:  dec_op = OP_LB;
          3'b001:  dec_op = OP_LH;
          3'b010:  dec_op = OP_LW;
          3'b100:  dec_op = OP_LBU;
          3'b101:  dec_op = OP_LHU;
          default: dec_op = '0;
        endcase
        if (dec_op != '0) dec_imm = imm_i;
      end
      7'b0100011: begin
        case (f3)
          3'b000:  dec_op = OP_SB;
          3'b001:  dec_op = OP_SH;
          3'b010:  dec_op = OP_SW;
          default: dec_op = '0;
        endcase
        if (dec_op != '0) dec_imm = imm_s;
      end
      7'b0010011: begin
        case (f3)
          3'b000: begin dec_op = OP_ADDI;  dec_imm = imm_i; end
          3'b010: begin dec_op = OP_SLTI;  dec_imm = imm_i; end
          3'b011: begin dec_op = OP_SLTIU; dec_imm = imm_i; end
          3'b100: begin dec_op = OP_XORI;  dec_imm = imm_i; end
          3'b110: begin dec_op = OP_ORI;   dec_imm = imm_i; end
          3'b111: begin dec_op = OP_ANDI;  dec_imm = imm_i; end
          3'b001: if (f7 == 7'b0000000) begin dec_op = OP_SLLI; dec_imm = imm_sh; end
          default: begin
            // funct3 101: logical or arithmetic right shift
            if (f7 == 7'b0000000) begin
              dec_op = OP_SRLI; dec_imm = imm_sh;
            end else if (f7 == 7'b0100000) begin
              dec_op = OP_SRAI; dec_imm = imm_sh;
            end
          end
        endcase
      end
      7'b0110011: begin
        case ({f7, f3})
          {7'b0000000, 3'b000}: dec_op = OP_ADD;
          {7'b0100000, 3'b000}: dec_op = OP_SUB;
          {7'b0000000, 3'b001}: dec_op = OP_SLL;
          {7'b0000000, 3'b010}: dec_op = OP_SLT;
          {7'b0000000, 3'b011}: dec_op = OP_SLTU;
          {7'b0000000, 3'b100}: dec_op = OP_XOR;
          {7'b0000000, 3'b101}: dec_op = OP_SRL;
          {7'b0100000, 3'b101}: dec_op = OP_SRA;
          {7'b0000000, 3'b110}: dec_op = OP_OR;
          {7'b0000000, 3'b111}: dec_op = OP_AND;
          default:              dec_op = '0;
        endcase
      end
      default: begin
        dec_op  = '0;
        dec_imm = '0;
      end
    endcase
  end

  // every decode output reads 0 while nothing valid is presented
  assign bus.out_valid = head_valid | bypass;
  assign bus.opcode    = bus.out_valid ? dec_op         : '0;
  assign bus.ophead    = bus.out_valid ? sel_ins[6:0]   : '0;
  assign bus.rs1       = bus.out_valid ? sel_ins[19:15] : '0;
  assign bus.rs2       = bus.out_valid ? sel_ins[24:20] : '0;
  assign bus.rd        = bus.out_valid ? sel_ins[11:7]  : '0;
  assign bus.imm       = bus.out_valid ? dec_imm        : '0;
  assign bus.pc        = bus.out_valid ? sel_pc         : '0;
  assign bus.illegal   = bus.out_valid & (dec_op == '0);
  assign bus.count     = cnt;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed tests for decode_queue (reset, decode, fill and
// drain with wrap, flush, illegal, rdy hold, same-cycle bypass behaviour).
module tb_decode_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int OPW   = 6;

  localparam logic [5:0] C_LUI = 6'd1, C_BEQ = 6'd5, C_ADDI = 6'd19, C_SRAI = 6'd27;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  decode_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .OPW(OPW)) bus ();

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_ins = 0; bus.in_pc = 0; bus.out_ready = 0;
    rst = 0; rdy = 1; flush = 0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_out_valid got=%b exp=0", bus.out_valid); end
    tick(); tick();
    rst = 1;
    tick();
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.opcode !== 6'd0) begin n_fail++; $display("FAIL reset_opcode got=%0d exp=0", bus.opcode); end
    n_checks++; if (bus.imm !== 32'd0) begin n_fail++; $display("FAIL reset_imm got=%h exp=0", bus.imm); end
    n_checks++; if (bus.pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", bus.pc); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    $display("reset done");
  endtask

  task automatic test_addi();
    bus.in_valid = 1; bus.in_ins = 32'hFFB10093; bus.in_pc = 32'h100; bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.opcode !== C_ADDI) begin n_fail++; $display("FAIL addi_opcode got=%0d exp=%0d", bus.opcode, C_ADDI); end
    n_checks++; if (bus.rs1 !== 5'd2) begin n_fail++; $display("FAIL addi_rs1 got=%0d exp=2", bus.rs1); end
    n_checks++; if (bus.rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd got=%0d exp=1", bus.rd); end
    n_checks++; if (bus.imm !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_imm got=%h exp=fffffffb", bus.imm); end
    n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got=%h exp=100", bus.pc); end
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal got=%b exp=0", bus.illegal); end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL addi_deq_count got=%0d exp=0", bus.count); end
    $display("addi pc=100 dequeued");
  endtask

  task automatic test_branch_lui();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_ins = 32'hFE000EE3; bus.in_pc = 32'h104;
    tick();
    bus.in_ins = 32'h123452B7; bus.in_pc = 32'h108;
    tick();
    bus.in_valid = 0;
    #1;
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL bl_count got=%0d exp=2", bus.count); end
    n_checks++; if (bus.opcode !== C_BEQ) begin n_fail++; $display("FAIL beq_opcode got=%0d exp=%0d", bus.opcode, C_BEQ); end
    n_checks++; if (bus.imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_imm got=%h exp=fffffffc", bus.imm); end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    $display("beq pc=104 dequeued");
    n_checks++; if (bus.opcode !== C_LUI) begin n_fail++; $display("FAIL lui_opcode got=%0d exp=%0d", bus.opcode, C_LUI); end
    n_checks++; if (bus.rd !== 5'd5) begin n_fail++; $display("FAIL lui_rd got=%0d exp=5", bus.rd); end
    n_checks++; if (bus.imm !== 32'h12345000) begin n_fail++; $display("FAIL lui_imm got=%h exp=12345000", bus.imm); end
    n_checks++; if (bus.pc !== 32'h108) begin n_fail++; $display("FAIL lui_pc got=%h exp=108", bus.pc); end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    $display("lui pc=108 dequeued");
  endtask

  task automatic test_fill_drain();
    logic [31:0] w;
    bus.out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
      bus.in_valid = 1; bus.in_ins = w; bus.in_pc = 32'h200 + 32'(4 * i);
      tick();
    end
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fill_count got=%0d exp=8", bus.count); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
    bus.in_ins = 32'h00A00513; bus.in_pc = 32'hDEAD;
    tick();
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_ignore_count got=%0d exp=8", bus.count); end
    bus.in_valid = 0; bus.out_ready = 1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_deq_in_ready got=%b exp=0", bus.in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (bus.pc !== 32'h200 + 32'(4 * i)) begin n_fail++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, bus.pc, 32'h200 + 32'(4 * i)); end
      n_checks++; if (bus.imm !== 32'(i)) begin n_fail++; $display("FAIL drain_imm[%0d] got=%h exp=%h", i, bus.imm, i); end
      n_checks++; if (bus.rd !== 5'(i + 1)) begin n_fail++; $display("FAIL drain_rd[%0d] got=%0d exp=%0d", i, bus.rd, i + 1); end
      $display("drain %0d pc=%h imm=%h", i, bus.pc, bus.imm);
      tick();
    end
    bus.out_ready = 0;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.in_ins = 32'h00100093; bus.in_pc = 32'h500 + 32'(4 * i);
      tick();
    end
    n_checks++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=5", bus.count); end
    flush = 1; bus.in_ins = 32'h00200113; bus.in_pc = 32'h600;
    tick();
    flush = 0; bus.in_valid = 0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got=%b exp=0", bus.out_valid); end
    $display("flush with count=5 done");
  endtask

  task automatic test_illegal_and_shift();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_ins = 32'h0000007F; bus.in_pc = 32'h700;
    tick();
    bus.in_ins = 32'h40525193; bus.in_pc = 32'h704;
    tick();
    bus.in_valid = 0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag got=%b exp=1", bus.illegal); end
    n_checks++; if (bus.opcode !== 6'd0) begin n_fail++; $display("FAIL ill_opcode got=%0d exp=0", bus.opcode); end
    n_checks++; if (bus.ophead !== 7'h7F) begin n_fail++; $display("FAIL ill_ophead got=%h exp=7f", bus.ophead); end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    $display("illegal pc=700 dequeued");
    n_checks++; if (bus.opcode !== C_SRAI) begin n_fail++; $display("FAIL srai_opcode got=%0d exp=%0d", bus.opcode, C_SRAI); end
    n_checks++; if (bus.imm !== 32'd5) begin n_fail++; $display("FAIL srai_imm got=%h exp=5", bus.imm); end
    n_checks++; if (bus.rs1 !== 5'd4) begin n_fail++; $display("FAIL srai_rs1 got=%0d exp=4", bus.rs1); end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    $display("srai pc=704 dequeued");
  endtask

  task automatic test_rdy_hold();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_ins = 32'h00100093; bus.in_pc = 32'h300;
    tick();
    rdy = 0; bus.out_ready = 1; bus.in_ins = 32'h00200113; bus.in_pc = 32'h304;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rdy0_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rdy0_valid got=%b exp=1", bus.out_valid); end
    tick();
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL rdy0_count got=%0d exp=1", bus.count); end
    n_checks++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL rdy0_pc got=%h exp=300", bus.pc); end
    rdy = 1; bus.in_valid = 0;
    tick();
    bus.out_ready = 0;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rdy1_count got=%0d exp=0", bus.count); end
    $display("rdy hold pc=300 dequeued");
  endtask

  task automatic test_bypass();
    bus.in_valid = 1; bus.in_ins = 32'hFFB10093; bus.in_pc = 32'h400; bus.out_ready = 1;
    #1;
`ifdef DECODE_BYPASS_EN
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.opcode !== C_ADDI) begin n_fail++; $display("FAIL byp_opcode got=%0d exp=%0d", bus.opcode, C_ADDI); end
    n_checks++; if (bus.pc !== 32'h400) begin n_fail++; $display("FAIL byp_pc got=%h exp=400", bus.pc); end
    tick();
    bus.in_valid = 0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL byp_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_after_valid got=%b exp=0", bus.out_valid); end
`else
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_valid got=%b exp=0", bus.out_valid); end
    tick();
    bus.in_valid = 0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL nobyp_next_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.pc !== 32'h400) begin n_fail++; $display("FAIL nobyp_pc got=%h exp=400", bus.pc); end
    tick();
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL nobyp_count got=%0d exp=0", bus.count); end
`endif
    bus.out_ready = 0;
    $display("bypass case pc=400 done");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch_lui();
    test_fill_drain();
    test_flush();
    test_illegal_and_shift();
    test_rdy_hold();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
